keypad_emulator: RTL and testbench

Behavioural-synthesizable model of a 4x4 matrix keypad: the device side of the column-scan / row-sense interface. It accepts key-press commands over a valid/ready handshake, then drives the row lines in response to whatever column is being driven low, including contact bounce on press and release. It sits opposite the keypad scanner/debouncer, in simulation benches and on-board self-test builds, so the scanner can be exercised without a physical keypad.

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/lfsr16.sv | 19 +
 rtl/keypad_emulator.sv | 133 +++++++++++++
 tb/tb_keypad_emulator.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator and the scanner that talks to it:
// FSM states, bounce LFSR constants and key_num field positions.
package keypad_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPressBounce,
      StHold,
      StReleaseBounce,
      StGap
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right-shifting register
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   localparam int unsigned ROW_MSB = 3;
   localparam int unsigned ROW_LSB = 2;
   localparam int unsigned COL_MSB = 1;
   localparam int unsigned COL_LSB = 0;

   localparam logic [3:0] KEY_IDLE = 4'b1111;

   function automatic logic [15:0] lfsr_step(input logic [15:0] q);
      return {^(q & LFSR_TAPS), q[15:1]};
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used as a contact-bounce source; seeded only by reset.
module lfsr16
   import keypad_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   output logic [15:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= LFSR_SEED;
      end else if (enable) begin
         q <= lfsr_step(q);
      end
   end

endmodule

// File: rtl/keypad_emulator.sv
// Device side of a 4x4 column-scan keypad: takes key-press commands and drives
// the row lines against the scanned column, with bounce on press and release.
module keypad_emulator
   import keypad_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES   = 200000,
   parameter int unsigned BOUNCE_CYCLES = 2000,
   parameter int unsigned GAP_CYCLES    = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_num,
   output logic       key_ready,
   input  logic [3:0] KEY_C,
   output logic [3:0] KEY_R,
   output logic       busy,
   output logic       done
);

   localparam logic [31:0] HOLD_LEN   = 32'(HOLD_CYCLES - 1);
   localparam logic [31:0] BOUNCE_LEN = 32'(BOUNCE_CYCLES - 1);
   localparam logic [31:0] GAP_LEN    = 32'(GAP_CYCLES - 1);

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [3:0]  key_q, key_d;
   logic        contact_q, contact_d;
   logic        done_q, done_d;
   logic [15:0] lfsr_q, lfsr_nxt;
   logic        lfsr_en;

   assign lfsr_en  = (state_q == StPressBounce) || (state_q == StReleaseBounce);
   // Value the LFSR will hold next cycle, so the registered contact lines up with it
   assign lfsr_nxt = lfsr_en ? lfsr_step(lfsr_q) : lfsr_q;

   lfsr16 u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .enable (lfsr_en),
      .q      (lfsr_q)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (key_valid) begin
               key_d = key_num;
               if (BOUNCE_CYCLES == 0) begin
                  state_d = StHold;
                  cnt_d   = HOLD_LEN;
               end else begin
                  state_d = StPressBounce;
                  cnt_d   = BOUNCE_LEN;
               end
            end
         end
         StPressBounce: begin
            if (cnt_q == 32'd0) begin
               state_d = StHold;
               cnt_d   = HOLD_LEN;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         StHold: begin
            if (cnt_q != 32'd0) begin
               cnt_d = cnt_q - 32'd1;
            end else if (BOUNCE_CYCLES == 0) begin
               state_d = StGap;
               cnt_d   = GAP_LEN;
            end else begin
               state_d = StReleaseBounce;
               cnt_d   = BOUNCE_LEN;
            end
         end
         StReleaseBounce: begin
            if (cnt_q == 32'd0) begin
               state_d = StGap;
               cnt_d   = GAP_LEN;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         StGap: begin
            if (cnt_q == 32'd0) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 32'd0;
         end
      endcase
      contact_d = (state_d == StHold) ||
                  (((state_d == StPressBounce) || (state_d == StReleaseBounce)) && lfsr_nxt[0]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= 32'd0;
         key_q     <= 4'd0;
         contact_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         key_q     <= key_d;
         contact_q <= contact_d;
         done_q    <= done_d;
      end
   end

   assign key_ready = (state_q == StIdle);
   assign busy      = ~key_ready;
   assign done      = done_q;

   always_comb begin
      KEY_R = KEY_IDLE;
      if (contact_q && !KEY_C[key_q[COL_MSB:COL_LSB]]) begin
         KEY_R = ~(4'b0001 << key_q[ROW_MSB:ROW_LSB]);
      end
   end

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized bench for keypad_emulator: two parameterisations checked every cycle
// against a timeline model of the press/release cycle.
module tb_keypad_emulator;

   localparam int unsigned B0 = 3;
   localparam int unsigned H0 = 5;
   localparam int unsigned G0 = 4;
   localparam int unsigned B1 = 0;
   localparam int unsigned H1 = 1;
   localparam int unsigned G1 = 1;

   logic             clk       = 1'b0;
   logic             rst       = 1'b1;
   logic             key_valid = 1'b0;
   logic [3:0]       key_num   = 4'h0;
   logic [3:0]       kc        = 4'hF;
   logic [1:0][3:0]  kr;
   logic [1:0]       ready;
   logic [1:0]       busy;
   logic [1:0]       done;

   int          tests = 0;
   int          fails = 0;
   int          bp[2];
   int          hp[2];
   int          gp[2];
   longint      cyc = 0;
   longint      acc[2];
   bit          have[2];
   logic [3:0]  km[2];
   logic [15:0] lm[2];
   bit          pin_on = 1'b0;
   logic [3:0]  pin_kr[11] = '{4'hE, 4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE,
                               4'hF, 4'hF, 4'hE};

   always #5 clk = ~clk;

   keypad_emulator #(.HOLD_CYCLES(H0), .BOUNCE_CYCLES(B0), .GAP_CYCLES(G0)) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_num   (key_num),
      .key_ready (ready[0]),
      .KEY_C     (kc),
      .KEY_R     (kr[0]),
      .busy      (busy[0]),
      .done      (done[0])
   );

   keypad_emulator #(.HOLD_CYCLES(H1), .BOUNCE_CYCLES(B1), .GAP_CYCLES(G1)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_num   (key_num),
      .key_ready (ready[1]),
      .KEY_C     (kc),
      .KEY_R     (kr[1]),
      .busy      (busy[1]),
      .done      (done[1])
   );

   function automatic logic [15:0] ref_step(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   // Position of the current cycle within instance i's press/release timeline
   function automatic void phase(input int i, output longint d, output bit idle,
                                 output bit bnc, output bit hold, output bit dn);
      int tot;
      tot  = 2 * bp[i] + hp[i] + gp[i];
      d    = have[i] ? cyc - acc[i] : 0;
      idle = !have[i] || d > tot;
      bnc  = have[i] && ((d >= 1 && d <= bp[i]) ||
                         (d > bp[i] + hp[i] && d <= 2 * bp[i] + hp[i]));
      hold = have[i] && d > bp[i] && d <= bp[i] + hp[i];
      dn   = have[i] && d == tot + 1;
   endfunction

   task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         have[i] = 1'b0;
         acc[i]  = 0;
         km[i]   = 4'h0;
         lm[i]   = 16'hACE1;
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         longint     d;
         bit         idle, bnc, hold, dn, ct;
         logic [3:0] e;
         phase(i, d, idle, bnc, hold, dn);
         ct = hold || (bnc && lm[i][0]);
         e  = (ct && !kc[km[i][1:0]]) ? ~(4'b0001 << km[i][3:2]) : 4'hF;
         cmp($sformatf("key_r%0d", i), kr[i], e);
         cmp($sformatf("key_ready%0d", i), {3'b0, ready[i]}, {3'b0, idle});
         cmp($sformatf("busy%0d", i), {3'b0, busy[i]}, {3'b0, !idle});
         cmp($sformatf("done%0d", i), {3'b0, done[i]}, {3'b0, dn});
         if (pin_on && i == 0 && have[0] && d >= 1 && d <= 11)
            cmp("pin_key_r", kr[0], pin_kr[d-1]);
         if (pin_on && i == 0 && have[0] && d == 16)
            cmp("pin_done", {3'b0, done[0]}, 4'h1);
      end
   endtask

   task automatic advance();
      for (int i = 0; i < 2; i++) begin
         longint d;
         bit     idle, bnc, hold, dn;
         phase(i, d, idle, bnc, hold, dn);
         if (bnc) lm[i] = ref_step(lm[i]);
         if (idle && key_valid) begin
            have[i] = 1'b1;
            acc[i]  = cyc;
            km[i]   = key_num;
         end
      end
      cyc++;
   endtask

   // Called at a falling edge; returns at the next falling edge
   task automatic cycle(input logic v, input logic [3:0] n, input logic [3:0] c);
      key_valid = v;
      key_num   = n;
      kc        = c;
      #1;
      check_all();
      @(posedge clk);
      advance();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      key_valid = 1'b0;
      model_reset();
      #1;
      check_all();
      cmp("rst_key_r", kr[0], 4'hF);
      cmp("rst_ready", {3'b0, ready[0]}, 4'h1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Key 0 with column 0 driven: literal bounce/hold/done pattern from the seed
   task automatic pin_run();
      pin_on = 1'b1;
      cycle(1'b1, 4'h0, 4'b1110);
      repeat (24) cycle(1'b0, 4'h0, 4'b1110);
      pin_on = 1'b0;
   endtask

   initial begin
      logic [3:0] c;
      logic [3:0] sh;
      bp = '{B0, B1};
      hp = '{H0, H1};
      gp = '{G0, G1};
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      check_all();
      cmp("init_key_r", kr[0], 4'hF);
      cmp("init_busy", {3'b0, busy[0]}, 4'h0);
      rst = 1'b0;

      pin_run();

      // Reset while key 5 (row 1, col 1) is solidly held
      cycle(1'b1, 4'h5, 4'b1101);
      repeat (5) cycle(1'b0, 4'h5, 4'b1101);
      #1;
      cmp("hold_key_r", kr[0], 4'b1101);
      do_reset();
      pin_run();

      repeat (4000) begin
         sh = 4'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) c = ~(4'b0001 << sh);
         else c = 4'($urandom);
         if ($urandom_range(0, 1499) == 0) do_reset();
         else cycle($urandom_range(0, 3) != 0, 4'($urandom), c);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
